// File: rtl/sum_sched_pkg.sv
// Shared types for the round-robin adder scheduler: FSM encoding, default widths, tag width.
// Pure declarations: no latency and no flow control.
package sum_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_DW    = 4;
    localparam int DEF_LAT   = 2;

    // A single requester still needs a 1-bit tag so the port never collapses to zero width.
    function automatic int tag_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sum_rr_core.sv
// Rotate-priority picker with registered pointer; grant is combinational from req and state.
// Zero-latency grant; no backpressure, a requester simply holds req until it sees its gnt bit.
module sum_rr_core
    import sum_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDW   = tag_w(DEF_N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  state_t           i_state,
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDW-1:0]   o_idx,
    output logic             o_take
);

    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] w_cand;
    logic           w_found;

    // N_REQ is a power of two, so IDW-bit addition wraps the scan back to index 0.
    always_comb begin
        w_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int j = 0; j < N_REQ; j++) begin
            w_cand = r_ptr + IDW'(j);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

    always_comb begin
        o_take = w_found && (i_state == ST_RUN) && i_en;
        o_gnt  = '0;
        if (o_take) o_gnt[o_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (o_take) begin
            r_ptr <= o_idx + 1'b1;
        end
    end

endmodule

// File: rtl/sum_rr_sched.sv
// Round-robin share of one LAT-deep DW-bit adder; result and tag return LAT cycles after grant,
// one issue per cycle, no result backpressure. SUM_RR_STATS_EN adds per-requester grant counters.
module sum_rr_sched
    import sum_sched_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    parameter  int DW    = DEF_DW,
    parameter  int LAT   = DEF_LAT,
    localparam int IDW   = tag_w(N_REQ)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] dataA,
    input  logic [N_REQ*DW-1:0] dataB,
    output logic [N_REQ-1:0]    gnt,
    output logic                res_valid,
    output logic [IDW-1:0]      res_idx,
    output logic [DW-1:0]       res_sum,
    output logic                idle
`ifdef SUM_RR_STATS_EN
    ,
    output logic [N_REQ*16-1:0] gnt_cnt
`endif
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IDW-1:0] w_idx;
    logic           w_issue;
    logic [DW-1:0]  w_a;
    logic [DW-1:0]  w_b;
    logic [DW-1:0]  w_sum;
    logic           w_busy_nxt;
    logic           w_any_vld;

    logic           r_vld [LAT];
    logic [DW-1:0]  r_sum [LAT];
    logic [IDW-1:0] r_tag [LAT];

    sum_rr_core #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .i_en    (en),
        .i_state (r_state),
        .i_req   (req),
        .o_gnt   (gnt),
        .o_idx   (w_idx),
        .o_take  (w_issue)
    );

    assign w_a   = dataA[w_idx*DW +: DW];
    assign w_b   = dataB[w_idx*DW +: DW];
    assign w_sum = w_a + w_b;

    // Looks one edge ahead so the FSM reaches IDLE on the same edge the last result retires.
    always_comb begin
        w_busy_nxt = 1'b0;
        w_any_vld  = 1'b0;
        for (int i = 0; i < LAT - 1; i++) w_busy_nxt = w_busy_nxt | r_vld[i];
        for (int i = 0; i < LAT; i++)     w_any_vld  = w_any_vld | r_vld[i];
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (en) w_state_nxt = ST_RUN;
            ST_RUN:   if (!en) w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (en)               w_state_nxt = ST_RUN;
                else if (!w_busy_nxt) w_state_nxt = ST_IDLE;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Data only moves behind a valid bit, which is what keeps res_idx/res_sum stable between strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) begin
                r_vld[i] <= 1'b0;
                r_sum[i] <= '0;
                r_tag[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_issue;
            if (w_issue) begin
                r_sum[0] <= w_sum;
                r_tag[0] <= w_idx;
            end
            for (int i = 1; i < LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) begin
                    r_sum[i] <= r_sum[i-1];
                    r_tag[i] <= r_tag[i-1];
                end
            end
        end
    end

    assign res_valid = r_vld[LAT-1];
    assign res_sum   = r_sum[LAT-1];
    assign res_idx   = r_tag[LAT-1];
    assign idle      = (r_state == ST_IDLE) && !w_any_vld;

`ifdef SUM_RR_STATS_EN
    logic [15:0] r_cnt [N_REQ];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_REQ; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (gnt[i] && (r_cnt[i] != 16'hFFFF)) r_cnt[i] <= r_cnt[i] + 16'd1;
            end
        end
    end

    always_comb begin
        gnt_cnt = '0;
        for (int i = 0; i < N_REQ; i++) gnt_cnt[i*16 +: 16] = r_cnt[i];
    end
`endif

endmodule

// File: tb/tb_sum_rr_sched.sv
// Directed bench for sum_rr_sched: reset, single op, fairness rotation, wrap, drain, mid-stream reset.
// Inputs change 1 ns after the rising edge; checks follow 1 ns later.
module tb_sum_rr_sched;

    logic        clk;
    logic        reset;
    logic        en;
    logic [3:0]  req;
    logic [15:0] dataA;
    logic [15:0] dataB;
    logic [3:0]  gnt;
    logic        res_valid;
    logic [1:0]  res_idx;
    logic [3:0]  res_sum;
    logic        idle;
`ifdef SUM_RR_STATS_EN
    logic [63:0] gnt_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    sum_rr_sched u_dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .req       (req),
        .dataA     (dataA),
        .dataB     (dataB),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_idx   (res_idx),
        .res_sum   (res_sum),
        .idle      (idle)
`ifdef SUM_RR_STATS_EN
        ,
        .gnt_cnt   (gnt_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
        dataA[i*4 +: 4] = a;
        dataB[i*4 +: 4] = b;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en    = 1'b0;
        req   = 4'b0000;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic [1:0] idx, input logic [3:0] sum);
        check({tag, "_vld"}, 32'(res_valid), 32'd1);
        check({tag, "_idx"}, 32'(res_idx), 32'(idx));
        check({tag, "_sum"}, 32'(res_sum), 32'(sum));
    endtask

    logic [3:0] t3_a [4] = '{4'd1, 4'd2, 4'd5, 4'd8};
    logic [3:0] t3_b [4] = '{4'd0, 4'd3, 4'd6, 4'd7};
    logic [3:0] t3_s [4] = '{4'd1, 4'd5, 4'd11, 4'd15};

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        req   = 4'b0000;
        dataA = '0;
        dataB = '0;

        do_reset();
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_vld", 32'(res_valid), 32'd0);
        check("rst_idx", 32'(res_idx), 32'd0);
        check("rst_sum", 32'(res_sum), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);

        // single op: 3+4 from requester 0
        tick(); en = 1'b1; #1;
        check("t2_idle_pre", 32'(idle), 32'd1);
        check("t2_gnt_idle", 32'(gnt), 32'd0);
        tick(); req = 4'b0001; set_op(0, 4'd3, 4'd4); #1;
        check("t2_gnt", 32'(gnt), 32'b0001);
        check("t2_idle_run", 32'(idle), 32'd0);
        tick(); req = 4'b0000; #1;
        check("t2_gnt_off", 32'(gnt), 32'd0);
        check("t2_vld_early", 32'(res_valid), 32'd0);
        tick(); #1;
        check_res("t2_res", 2'd0, 4'd7);

        // all four requesting: strict rotation, results in grant order
        do_reset();
        tick(); en = 1'b1;
        for (int i = 0; i < 4; i++) set_op(i, t3_a[i], t3_b[i]);
        for (int k = 0; k < 11; k++) begin
            tick();
            req = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            check($sformatf("t3_gnt%0d", k), 32'(gnt), (k < 8) ? (32'd1 << (k % 4)) : 32'd0);
            if (k >= 2 && k < 10) begin
                check_res($sformatf("t3_res%0d", k), 2'((k - 2) % 4), t3_s[(k - 2) % 4]);
            end else begin
                check($sformatf("t3_novld%0d", k), 32'(res_valid), 32'd0);
            end
        end
        check("t3_hold_idx", 32'(res_idx), 32'd3);
        check("t3_hold_sum", 32'(res_sum), 32'd15);

        // carry discarded: 9+9 -> 2, 15+1 -> 0; pointer wraps 3 -> 0
        tick(); req = 4'b0100; set_op(2, 4'd9, 4'd9); #1;
        check("t4_gnt2", 32'(gnt), 32'b0100);
        tick(); req = 4'b0001; set_op(0, 4'd15, 4'd1); #1;
        check("t4_gnt0", 32'(gnt), 32'b0001);
        tick(); req = 4'b0000; #1;
        check_res("t4_res2", 2'd2, 4'd2);
        tick(); #1;
        check_res("t4_res0", 2'd0, 4'd0);

        // two back-to-back ops, then en drops while req is still up
        tick(); req = 4'b0011; set_op(0, 4'd1, 4'd1); set_op(1, 4'd2, 4'd3); #1;
        check("t5_gnt1", 32'(gnt), 32'b0010);
        tick(); req = 4'b0001; #1;
        check("t5_gnt0", 32'(gnt), 32'b0001);
        tick(); en = 1'b0; #1;
        check("t5_gnt_en0", 32'(gnt), 32'd0);
        check_res("t5_res1", 2'd1, 4'd5);
        tick(); #1;
        check("t5_gnt_drain", 32'(gnt), 32'd0);
        check_res("t5_res0", 2'd0, 4'd2);
        check("t5_idle_drain", 32'(idle), 32'd0);
        tick(); req = 4'b0000; #1;
        check("t5_vld_done", 32'(res_valid), 32'd0);
        check("t5_idle_done", 32'(idle), 32'd1);

        // reset with ops in flight: nothing may come back afterwards
        tick(); en = 1'b1;
        tick(); req = 4'b1111; #1;
        check("t1_gnt_a", 32'(gnt), 32'b0010);
        tick(); #1;
        check("t1_gnt_b", 32'(gnt), 32'b0100);
        tick();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            check($sformatf("t1_vld%0d", k), 32'(res_valid), 32'd0);
            check($sformatf("t1_idle%0d", k), 32'(idle), 32'd1);
            check($sformatf("t1_gnt%0d", k), 32'(gnt), 32'd0);
        end

`ifdef SUM_RR_STATS_EN
        do_reset();
        #1;
        check("t6_cnt_rst", 32'(gnt_cnt == 64'd0), 32'd1);
        tick(); en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(); req = 4'b0101; #1;
            check($sformatf("t6_gnt%0d", k), 32'(gnt), (k % 2 == 0) ? 32'b0001 : 32'b0100);
        end
        tick(); req = 4'b0000; #1;
        check("t6_cnt0", 32'(gnt_cnt[15:0]), 32'd5);
        check("t6_cnt1", 32'(gnt_cnt[31:16]), 32'd0);
        check("t6_cnt2", 32'(gnt_cnt[47:32]), 32'd5);
        check("t6_cnt3", 32'(gnt_cnt[63:48]), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
